// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, small FIFO,
// and a start/data/stop serialiser driving a registered io_tx line.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          bit_done;

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign tx_ready = (fifo_count != COUNT_FULL);
  assign push     = tx_valid && tx_ready;
  // A byte is only taken from a non-empty queue when the line is idle or
  // the stop bit is finishing, so back-to-back frames have no idle gap.
  assign pop      = (fifo_count != '0) &&
                    ((state == IDLE) || ((state == STOP) && bit_done));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // Byte storage: written at the write pointer on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Queue pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame serialiser; io_tx is set alongside each state change so the
  // registered line level always matches the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      io_tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          io_tx    <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            io_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            io_tx    <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              io_tx <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              io_tx   <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              io_tx <= 1'b0;
            end else begin
              state <= IDLE;
              io_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          io_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_buffered;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       io_tx;
  logic       busy;
  logic [3:0] fifo_count;

  int total = 0;
  int bad   = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .io_tx      (io_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference receiver: finds a start bit, samples each bit mid-period
  logic [7:0] rx_q [$];
  logic [7:0] rx_sh;
  int         rx_cnt = 0;
  bit         rx_active = 0;
  int         rx_stop_err = 0;

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (io_tx == 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && (rx_cnt % CPB) == CPB/2)
        rx_sh[(rx_cnt - CPB) / CPB] = io_tx;
      if (rx_cnt == 9*CPB + CPB/2) begin
        if (io_tx !== 1'b1) rx_stop_err++;
        rx_q.push_back(rx_sh);
        rx_active = 0;
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
  } vec_t;

  vec_t vecs [4];

  // Push one byte into an idle transmitter and check the whole frame
  task automatic single_frame(input logic [7:0] d, input logic [9:0] f);
    @(posedge clk); #1;
    chk("pre_ready", tx_ready, 1);
    chk("pre_busy", busy, 0);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("n1_count", fifo_count, 1);
    chk("n1_io_tx", io_tx, 1);
    chk("n1_busy", busy, 1);
    for (int k = 0; k < 10*CPB; k++) begin
      @(posedge clk); #1;
      chk($sformatf("frame_%0h_c%0d", d, k), io_tx, f[k / CPB]);
      if (k == 0) chk("n2_count", fifo_count, 0);
    end
    chk("n41_busy", busy, 1);
    @(posedge clk); #1;
    chk("n42_busy", busy, 0);
    chk("n42_io_tx", io_tx, 1);
  endtask

  logic [7:0] bytes3 [3];
  logic       exp_bits [120];
  logic [7:0] exp_full [10];
  logic [7:0] stream [20];
  bit         low_seen;
  bit         accepted;
  bit         acc_now;
  int         waited;
  int         f_idx;
  int         pos;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h01, 10'b1000000010};
    vecs[3] = '{8'h80, 10'b1100000000};

    // Asynchronous reset asserted between clock edges
    #2 reset = 1'b1;
    #1;
    chk("rst_io_tx", io_tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Single-byte frames from the vector table
    for (int i = 0; i < 4; i++) single_frame(vecs[i].data, vecs[i].frame);

    // Back-to-back: three pushes on consecutive cycles
    bytes3[0] = 8'h00; bytes3[1] = 8'hFF; bytes3[2] = 8'h55;
    for (int k = 0; k < 120; k++) begin
      f_idx = k / (10*CPB);
      pos   = (k % (10*CPB)) / CPB;
      if (pos == 0)      exp_bits[k] = 1'b0;
      else if (pos == 9) exp_bits[k] = 1'b1;
      else               exp_bits[k] = bytes3[f_idx][pos-1];
    end
    @(posedge clk); #1;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_n1_count", fifo_count, 1);
    tx_data = 8'hFF;
    @(posedge clk); #1;
    chk("b2b_n2_count", fifo_count, 1);
    chk("b2b_n2_io_tx", io_tx, exp_bits[0]);
    tx_data = 8'h55;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("b2b_n3_count", fifo_count, 2);
    for (int k = 1; k < 120; k++) begin
      chk($sformatf("b2b_bit_c%0d", k), io_tx, exp_bits[k]);
      if (k == 39)  chk("b2b_count_41", fifo_count, 2);
      if (k == 40)  chk("b2b_count_42", fifo_count, 1);
      if (k == 79)  chk("b2b_count_81", fifo_count, 1);
      if (k == 80)  chk("b2b_count_82", fifo_count, 0);
      if (k == 119) chk("b2b_busy_last", busy, 1);
      @(posedge clk); #1;
    end
    chk("b2b_busy_end", busy, 0);
    chk("b2b_io_tx_end", io_tx, 1);

    // Full FIFO: valid held high, data incrementing every cycle
    rx_q.delete();
    rx_stop_err = 0;
    for (int i = 0; i < 9; i++) exp_full[i] = 8'h10 + 8'(i);
    exp_full[9] = 8'h3A;
    @(posedge clk); #1;
    for (int k = 0; k < 46; k++) begin
      tx_valid = 1'b1;
      tx_data  = 8'h10 + 8'(k);
      if (k == 8)  chk("full_ready_n8", tx_ready, 1);
      if (k == 9)  chk("full_ready_n9", tx_ready, 0);
      if (k == 9)  chk("full_count_n9", fifo_count, 8);
      if (k == 41) chk("full_ready_n41", tx_ready, 0);
      if (k == 42) chk("full_ready_n42", tx_ready, 1);
      if (k == 43) chk("full_ready_n43", tx_ready, 0);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    waited = 0;
    while (busy && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (4) @(posedge clk); #1;
    chk("full_drain_timeout", (waited < 1000), 1);
    chk("full_rx_count", rx_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("full_rx_%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_full[i]);
    chk("full_stop_err", rx_stop_err, 0);

    // Wrap-around: 20 bytes through the depth-8 queue
    rx_q.delete();
    rx_stop_err = 0;
    for (int i = 0; i < 20; i++) stream[i] = 8'(i * 29 + 7);
    for (int i = 0; i < 20; i++) begin
      tx_data  = stream[i];
      tx_valid = 1'b1;
      accepted = 0;
      waited   = 0;
      while (!accepted && waited < 200) begin
        acc_now = tx_ready;
        @(posedge clk); #1;
        if (acc_now) accepted = 1;
        waited++;
      end
      if (!accepted) chk($sformatf("wrap_push_timeout_%0d", i), 0, 1);
    end
    tx_valid = 1'b0;
    waited = 0;
    while (rx_q.size() < 20 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("wrap_rx_count", rx_q.size(), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("wrap_rx_%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, stream[i]);
    chk("wrap_stop_err", rx_stop_err, 0);
    repeat (4) @(posedge clk); #1;
    chk("wrap_idle_busy", busy, 0);

    // Reset during data bit 3 of a 0x00 frame with three bytes queued
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'h00;
    @(posedge clk); #1; tx_data = 8'h11;
    @(posedge clk); #1; tx_data = 8'h22;
    @(posedge clk); #1; tx_data = 8'h33;
    @(posedge clk); #1; tx_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_io_tx_low", io_tx, 0);
    chk("mid_count", fifo_count, 3);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_io_tx", io_tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", tx_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    low_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (io_tx !== 1'b1) low_seen = 1;
    end
    chk("mid_no_low_after_reset", low_seen, 0);
    chk("mid_busy_after", busy, 0);
    single_frame(vecs[1].data, vecs[1].frame);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
